// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the fetch PC, drives the instruction-memory address, and latches the
// fetched word and its PC for decode. Stalls hold everything. Redirects load
// the branch target and flush IF/ID with a bubble. Event counters track
// accepted fetches, stalled cycles and redirect cycles.
module if_id_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [63:0]      branch_target,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [63:0]      pc_out,
    output logic [63:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [63:0]      pc_q,        pc_d;
    logic [63:0]      if_pc_q,     if_pc_d;
    logic [31:0]      if_instr_q,  if_instr_d;
    logic             if_valid_q,  if_valid_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next-state selection: redirect beats stall (older instruction), stall beats advance.
    always_comb begin
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (branch_taken) begin
            // Target is forced word-aligned; the word fetched this cycle is dropped.
            pc_d        = branch_target & ~64'h3;
            if_pc_d     = 64'h0;
            if_instr_d  = NOP_INSTR;
            if_valid_d  = 1'b0;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            pc_d        = pc_q + 64'd4;
            if_pc_d     = pc_q;
            if_instr_d  = imem_rdata;
            if_valid_d  = 1'b1;
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            if_pc_q     <= 64'h0;
            if_instr_q  <= NOP_INSTR;
            if_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign if_id_pc    = if_pc_q;
    assign if_id_instr = if_instr_q;
    assign if_id_valid = if_valid_q;
    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, all checked against a behavioural model.
module tb_if_id_fetch_stage;

    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          CNT_W     = 32;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             branch_taken;
    logic [63:0]      branch_target;
    logic [63:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [63:0]      pc_out;
    logic [63:0]      if_id_pc;
    logic [31:0]      if_id_instr;
    logic             if_id_valid;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [63:0]      m_pc;
    logic [63:0]      m_ifpc;
    logic [31:0]      m_instr;
    logic             m_valid;
    logic [CNT_W-1:0] m_fetch, m_stall, m_flush;

    if_id_fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: fixed words at the start, hashed elsewhere.
    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = a[31:0];
        hi = a[63:32];
        case (a)
            64'h0:   return 32'h0010_0093;
            64'h4:   return 32'h0020_0113;
            64'h8:   return 32'h0030_8193;
            default: return (lo * 32'h9E37_79B1) ^ hi ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign imem_rdata = mem_fn(imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pc"},     pc_out,      m_pc);
        chk({tag, "_addr"},   imem_addr,   m_pc);
        chk({tag, "_ifpc"},   if_id_pc,    m_ifpc);
        chk({tag, "_instr"},  {32'h0, if_id_instr}, {32'h0, m_instr});
        chk({tag, "_valid"},  {63'h0, if_id_valid}, {63'h0, m_valid});
        chk({tag, "_fetch"},  {32'h0, fetch_count}, {32'h0, m_fetch});
        chk({tag, "_stall"},  {32'h0, stall_count}, {32'h0, m_stall});
        chk({tag, "_flush"},  {32'h0, flush_count}, {32'h0, m_flush});
    endtask

    // One clock edge: drive inputs, confirm no input-to-output leak, update model, compare.
    task automatic step(input logic r, input logic s, input logic b,
                        input logic [63:0] tgt, input string tag);
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        #1;
        if (!$isunknown(m_pc)) begin
            chk({tag, "_comb_pc"}, pc_out, m_pc);
            chk({tag, "_comb_addr"}, imem_addr, m_pc);
        end
        if (r) begin
            m_pc = RESET_PC; m_ifpc = 64'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
            m_fetch = '0; m_stall = '0; m_flush = '0;
        end else if (b) begin
            m_pc = {tgt[63:2], 2'b00};
            m_ifpc = 64'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
            m_flush = m_flush + 1;
        end else if (s) begin
            m_stall = m_stall + 1;
        end else begin
            m_ifpc  = m_pc;
            m_instr = mem_fn(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            m_fetch = m_fetch + 1;
        end
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    initial begin
        logic [63:0] tgt;
        logic        r, s, b;
        m_pc = 'x;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
        @(negedge clk);

        // 1: reset and sequential fetch
        step(1, 0, 0, 64'h0, "t1_reset");
        chk("t1_rst_pc", pc_out, 64'h0);
        chk("t1_rst_valid", {63'h0, if_id_valid}, 64'h0);
        step(0, 0, 0, 64'h0, "t1_adv0");
        chk("t1_ifpc0", if_id_pc, 64'h0);
        chk("t1_instr0", {32'h0, if_id_instr}, 64'h0010_0093);
        chk("t1_pc4", pc_out, 64'h4);
        step(0, 0, 0, 64'h0, "t1_adv1");
        chk("t1_instr1", {32'h0, if_id_instr}, 64'h0020_0113);
        step(0, 0, 0, 64'h0, "t1_adv2");
        chk("t1_fetch3", {32'h0, fetch_count}, 64'd3);

        // 2: stall hold
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 64'h0, "t2_stall");
            chk("t2_pc_hold", pc_out, 64'hC);
            chk("t2_ifpc_hold", if_id_pc, 64'h8);
            chk("t2_instr_hold", {32'h0, if_id_instr}, 64'h0030_8193);
        end
        chk("t2_stall3", {32'h0, stall_count}, 64'd3);
        step(0, 0, 0, 64'h0, "t2_release");
        chk("t2_ifpc_c", if_id_pc, 64'hC);

        // 3: redirect at pc 0x10
        chk("t3_pre_pc", pc_out, 64'h10);
        step(0, 0, 1, 64'h40, "t3_redir");
        chk("t3_pc40", pc_out, 64'h40);
        chk("t3_nop", {32'h0, if_id_instr}, {32'h0, NOP_INSTR});
        chk("t3_valid0", {63'h0, if_id_valid}, 64'h0);
        chk("t3_flush1", {32'h0, flush_count}, 64'd1);
        step(0, 0, 0, 64'h0, "t3_after");
        chk("t3_ifpc40", if_id_pc, 64'h40);
        chk("t3_valid1", {63'h0, if_id_valid}, 64'h1);

        // 4: simultaneous stall and branch, misaligned target
        step(0, 1, 1, 64'h83, "t4_both");
        chk("t4_pc80", pc_out, 64'h80);
        chk("t4_flush2", {32'h0, flush_count}, 64'd2);
        chk("t4_stall3", {32'h0, stall_count}, 64'd3);
        chk("t4_valid0", {63'h0, if_id_valid}, 64'h0);

        // back-to-back redirects: last one wins
        step(0, 0, 1, 64'h200, "bb_redir0");
        step(0, 0, 1, 64'h305, "bb_redir1");
        chk("bb_pc", pc_out, 64'h304);
        step(0, 0, 0, 64'h0, "bb_adv");
        chk("bb_ifpc", if_id_pc, 64'h304);

        // 5: PC wrap
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, "t5_redir");
        step(0, 0, 0, 64'h0, "t5_adv");
        chk("t5_pc0", pc_out, 64'h0);
        chk("t5_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_valid", {63'h0, if_id_valid}, 64'h1);

        // 6: reset mid-stall at pc 0x20
        step(0, 0, 1, 64'h20, "t6_redir");
        step(0, 1, 0, 64'h0, "t6_stall");
        chk("t6_pc20", pc_out, 64'h20);
        step(1, 1, 0, 64'h0, "t6_reset");
        chk("t6_pc_rst", pc_out, RESET_PC);
        chk("t6_valid", {63'h0, if_id_valid}, 64'h0);
        chk("t6_instr", {32'h0, if_id_instr}, {32'h0, NOP_INSTR});
        chk("t6_cnts", {32'h0, fetch_count | stall_count | flush_count}, 64'h0);
        step(0, 0, 0, 64'h0, "t6_first");
        chk("t6_first_ifpc", if_id_pc, RESET_PC);

        // reset during a redirect
        step(1, 0, 1, 64'h1000, "rst_vs_branch");
        chk("rvb_pc", pc_out, RESET_PC);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 15);
            tgt = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(tgt[3:0]);
            step(r, s, b, tgt, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
